// File: rtl/masked_sbox_layer_seq.sv
// Sequencer that runs a 3-share masked state through one shared quadratic S-box layer.
// Optional SBOX_SEQ_ZEROIZE_EN clears shares/outputs after hand-off and blanks idle layer inputs.
module masked_sbox_layer_seq #(
    parameter int unsigned NIBBLES = 16,
    parameter int unsigned PASSES  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] s_in1,
    input  logic [4*NIBBLES-1:0] s_in2,
    input  logic [4*NIBBLES-1:0] s_in3,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] s_out1,
    output logic [4*NIBBLES-1:0] s_out2,
    output logic [4*NIBBLES-1:0] s_out3,
    input  logic [19:0]          rnd_in,
    input  logic                 rnd_valid,
    output logic                 rnd_ready,
    output logic [3:0]           lay_in1,
    output logic [3:0]           lay_in2,
    output logic [3:0]           lay_in3,
    output logic [1:0]           lay_sel,
    output logic [11:0]          lay_r,
    output logic [3:0]           lay_rc0,
    output logic [3:0]           lay_rc1,
    input  logic [3:0]           lay_out1,
    input  logic [3:0]           lay_out2,
    input  logic [3:0]           lay_out3
);

    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned NibW = $clog2(NIBBLES);

    typedef enum logic [1:0] {StIdle, StRun, StWait, StDone} state_e;

    state_e          state_q;
    logic [W-1:0]    sh1_q, sh2_q, sh3_q;
    logic [W-1:0]    sh1_ret, sh2_ret, sh3_ret;
    logic [NibW-1:0] nib_cnt_q, ret_nib_q;
    logic [1:0]      pass_cnt_q;
    logic            ret_pending_q;
    logic            issue, last_nib, last_issue;

    assign issue      = (state_q == StRun) && rnd_valid;
    assign rnd_ready  = issue;
    assign last_nib   = (nib_cnt_q == NibW'(NIBBLES - 1));
    assign last_issue = issue && last_nib && (pass_cnt_q == 2'(PASSES - 1));

    // Shares with the in-flight layer result merged in; WAIT captures from here so the
    // final return lands in s_out on the same edge.
    always_comb begin
        sh1_ret = sh1_q;
        sh2_ret = sh2_q;
        sh3_ret = sh3_q;
        if (ret_pending_q) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (ret_nib_q == NibW'(i)) begin
                    sh1_ret[4*i +: 4] = lay_out1;
                    sh2_ret[4*i +: 4] = lay_out2;
                    sh3_ret[4*i +: 4] = lay_out3;
                end
            end
        end
    end

    always_comb begin
        lay_in1 = '0;
        lay_in2 = '0;
        lay_in3 = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (nib_cnt_q == NibW'(i)) begin
                lay_in1 = sh1_q[4*i +: 4];
                lay_in2 = sh2_q[4*i +: 4];
                lay_in3 = sh3_q[4*i +: 4];
            end
        end
        lay_sel = pass_cnt_q;
        lay_r   = rnd_in[11:0];
        lay_rc0 = rnd_in[15:12];
        lay_rc1 = rnd_in[19:16];
`ifdef SBOX_SEQ_ZEROIZE_EN
        if (!issue) begin
            lay_in1 = '0;
            lay_in2 = '0;
            lay_in3 = '0;
            lay_r   = '0;
            lay_rc0 = '0;
            lay_rc1 = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            sh1_q         <= '0;
            sh2_q         <= '0;
            sh3_q         <= '0;
            s_out1        <= '0;
            s_out2        <= '0;
            s_out3        <= '0;
            nib_cnt_q     <= '0;
            pass_cnt_q    <= '0;
            ret_nib_q     <= '0;
            ret_pending_q <= 1'b0;
            busy          <= 1'b0;
            out_valid     <= 1'b0;
        end else begin
            ret_pending_q <= issue;
            if (issue) ret_nib_q <= nib_cnt_q;
            sh1_q <= sh1_ret;
            sh2_q <= sh2_ret;
            sh3_q <= sh3_ret;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        sh1_q      <= s_in1;
                        sh2_q      <= s_in2;
                        sh3_q      <= s_in3;
                        nib_cnt_q  <= '0;
                        pass_cnt_q <= '0;
                        busy       <= 1'b1;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    if (issue) begin
                        if (last_issue) begin
                            nib_cnt_q  <= '0;
                            pass_cnt_q <= '0;
                            state_q    <= StWait;
                        end else if (last_nib) begin
                            nib_cnt_q  <= '0;
                            pass_cnt_q <= pass_cnt_q + 2'd1;
                        end else begin
                            nib_cnt_q <= nib_cnt_q + 1'b1;
                        end
                    end
                end
                StWait: begin
                    s_out1    <= sh1_ret;
                    s_out2    <= sh2_ret;
                    s_out3    <= sh3_ret;
                    out_valid <= 1'b1;
                    state_q   <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state_q   <= StIdle;
`ifdef SBOX_SEQ_ZEROIZE_EN
                        sh1_q  <= '0;
                        sh2_q  <= '0;
                        sh3_q  <= '0;
                        s_out1 <= '0;
                        s_out2 <= '0;
                        s_out3 <= '0;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_masked_sbox_layer_seq.sv
// Randomized bench for masked_sbox_layer_seq with a behavioural masked layer model.
module tb_masked_sbox_layer_seq;

    localparam int unsigned N  = 16;
    localparam int unsigned P  = 3;
    localparam int unsigned NP = N * P;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0, rnd_valid = 1'b1;
    logic        busy, out_valid, rnd_ready;
    logic [63:0] s_in1 = '0, s_in2 = '0, s_in3 = '0;
    logic [63:0] s_out1, s_out2, s_out3;
    logic [19:0] rnd_in = '0;
    logic [3:0]  lay_in1, lay_in2, lay_in3, lay_rc0, lay_rc1;
    logic [1:0]  lay_sel;
    logic [11:0] lay_r;
    logic [3:0]  lay_out1 = '0, lay_out2 = '0, lay_out3 = '0;

    int          tests = 0;
    int          fails = 0;
    int          issue_cnt = 0;
    bit          toggle_mode = 1'b0;
    logic [3:0]  sbox [16];
    logic [3:0]  g0 [16];
    logic [3:0]  g1 [16];
    logic [3:0]  g2 [16];
    logic [3:0]  exp_vals [16];
    logic [63:0] exp_res = '0;

    masked_sbox_layer_seq #(.NIBBLES(N), .PASSES(P)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .s_in1(s_in1), .s_in2(s_in2), .s_in3(s_in3),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .s_out1(s_out1), .s_out2(s_out2), .s_out3(s_out3),
        .rnd_in(rnd_in), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .lay_in1(lay_in1), .lay_in2(lay_in2), .lay_in3(lay_in3),
        .lay_sel(lay_sel), .lay_r(lay_r), .lay_rc0(lay_rc0), .lay_rc1(lay_rc1),
        .lay_out1(lay_out1), .lay_out2(lay_out2), .lay_out3(lay_out3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] stage(input int s, input logic [3:0] x);
        case (s)
            0:       return g0[x];
            1:       return g1[x];
            2:       return g2[x];
            default: return x;
        endcase
    endfunction

    // Layer model: the three stages compose to the SKINNY S-box; outputs are re-masked.
    initial begin
        logic [3:0] x, y, m1, m2, p1, p2, p3;
        p1 = '0; p2 = '0; p3 = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rnd_ready) begin
                    check("issue_budget", 64'(issue_cnt < NP), 64'd1);
                    check("lay_sel", 64'(lay_sel), 64'(issue_cnt / N));
                    x = lay_in1 ^ lay_in2 ^ lay_in3;
                    check("lay_in", 64'(x), 64'(exp_vals[issue_cnt % N]));
                    check("lay_rnd", 64'({lay_rc1, lay_rc0, lay_r}), 64'(rnd_in));
                    exp_vals[issue_cnt % N] = stage(issue_cnt / N, exp_vals[issue_cnt % N]);
                    y  = stage(int'(lay_sel), x);
                    m1 = lay_r[3:0] ^ lay_rc0;
                    m2 = lay_r[7:4] ^ lay_rc1;
                    p1 = y ^ m1 ^ m2;
                    p2 = m1;
                    p3 = m2;
                    issue_cnt++;
                end
`ifdef SBOX_SEQ_ZEROIZE_EN
                else begin
                    check("zero_lay", 64'({lay_in1, lay_in2, lay_in3, lay_r, lay_rc0, lay_rc1}),
                          64'd0);
                end
`endif
            end
            @(posedge clk);
            #1;
            lay_out1 = p1;
            lay_out2 = p2;
            lay_out3 = p3;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rnd_in    = 20'($urandom);
        rnd_valid = toggle_mode ? ~rnd_valid : 1'b1;
    endtask

    task automatic start_op(input logic [63:0] x);
        logic [63:0] m1, m2;
        m1 = {$urandom, $urandom};
        m2 = {$urandom, $urandom};
        s_in1 = m1;
        s_in2 = m2;
        s_in3 = x ^ m1 ^ m2;
        for (int n = 0; n < N; n++) begin
            exp_vals[n]       = x[4*n +: 4];
            exp_res[4*n +: 4] = sbox[x[4*n +: 4]];
        end
        issue_cnt = 0;
        start     = 1'b1;
        rnd_valid = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int exp_lat);
        int j;
        j = 1;
        while (!out_valid && j < 400) begin
            tick();
            j++;
        end
        check("latency", 64'(j), 64'(exp_lat));
        check("issues", 64'(issue_cnt), 64'(NP));
        check("result", s_out1 ^ s_out2 ^ s_out3, exp_res);
        check("busy_done", 64'(busy), 64'd1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("valid_drop", 64'(out_valid), 64'd0);
        check("busy_drop", 64'(busy), 64'd0);
`ifdef SBOX_SEQ_ZEROIZE_EN
        check("sout_zero", s_out1 | s_out2 | s_out3, 64'd0);
`else
        check("sout_held", s_out1 ^ s_out2 ^ s_out3, exp_res);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] snap1, snap2;
        sbox = '{4'hc, 4'h6, 4'h9, 4'h0, 4'h1, 4'ha, 4'h2, 4'hb,
                 4'h3, 4'h8, 4'h5, 4'hd, 4'h4, 4'he, 4'h7, 4'hf};
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v     = 4'(i);
            g0[i] = v + 4'd3;
            g1[i] = {v[2:0], v[3]} ^ 4'h5;
        end
        for (int i = 0; i < 16; i++) g2[g1[g0[i]]] = sbox[i];

        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_rnd_ready", 64'(rnd_ready), 64'd0);
        check("rst_sout", s_out1 | s_out2 | s_out3, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        toggle_mode = 1'b0;
        start_op(64'h0123456789ABCDEF);
        wait_done(50);
        handshake();

        toggle_mode = 1'b1;
        start_op({$urandom, $urandom});
        wait_done(98);

        toggle_mode = 1'b0;
        snap1 = s_out1;
        snap2 = s_out2;
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            tick();
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_busy", 64'(busy), 64'd1);
            check("hold_s1", s_out1, snap1);
            check("hold_s2", s_out2, snap2);
        end
        start = 1'b0;
        check("hold_result", s_out1 ^ s_out2 ^ s_out3, exp_res);
        handshake();

        start_op({$urandom, $urandom});
        wait_done(50);
        handshake();

        start_op({$urandom, $urandom});
        repeat (19) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_rnd_ready", 64'(rnd_ready), 64'd0);
        check("arst_s1", s_out1, 64'd0);
        check("arst_s2", s_out2, 64'd0);
        check("arst_s3", s_out3, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        start_op({$urandom, $urandom});
        wait_done(50);
        handshake();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/masked_sbox_layer_seq.md
# masked_sbox_layer_seq

Iterative sequencer that pushes a 3-share (second-order) masked 64-bit SKINNY state through one shared quadratic S-box layer instance. The layer computes one 4-bit quadratic stage per invocation and has one cycle of latency. The sequencer invokes it PASSES times per nibble to build the full S-box, and pulls one fresh randomness word per invocation from the RNG interface. It sits between the round controller and the single shared masked S-box layer of the cipher core.

## Interface
- NIBBLES, default 16: nibbles per share. Must be at least 2.
- PASSES, default 3: quadratic stages per S-box.
- clk  in  1: clock, rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- start  in  1: request to process the s_in shares. Sampled only in IDLE.
- s_in1, s_in2, s_in3  in  4*NIBBLES: input shares.
- busy  out  1: high in every state except IDLE.
- out_valid  out  1: result shares valid. Held until out_ready.
- out_ready  in  1: result consumed.
- s_out1, s_out2, s_out3  out  4*NIBBLES: result shares, registered.
- rnd_in  in  20: fresh randomness, packed as {rc1[3:0], rc0[3:0], r[11:0]}.
- rnd_valid  in  1: rnd_in is valid.
- rnd_ready  out  1: the word is consumed this cycle.
- lay_in1, lay_in2, lay_in3  out  4: layer input shares for the nibble being issued.
- lay_sel  out  2: quadratic stage index, 0..PASSES-1.
- lay_r  out  12, lay_rc0  out  4, lay_rc1  out  4: the randomness word, passed straight through to the layer.
- lay_out1, lay_out2, lay_out3  in  4: layer result, valid one cycle after issue.

## Operation
- States: IDLE, RUN, WAIT, DONE.
- IDLE, start=1: capture s_in1..3 into the share registers, clear nib_cnt and pass_cnt, go to RUN.
- RUN, issue condition: issue = rnd_valid.
  - rnd_ready = issue. It is combinational and never high outside RUN.
  - lay_in* = nibble nib_cnt of the current shares; lay_sel = pass_cnt.
  - Each randomness word is used for exactly one invocation and is never reused.
- RUN, rnd_valid=0: stall. No issue, counters hold, rnd_ready=0.
- Counters on issue: nib_cnt increments. At NIBBLES-1 it wraps to 0 and pass_cnt increments.
- Last invocation (nib_cnt=NIBBLES-1, pass_cnt=PASSES-1) issued: go to WAIT.
- Result return:
  - An internal ret_pending flop is set by issue and records the issued nibble index.
  - In the cycle after an issue, lay_out1..3 are written into that nibble of share 1..3.
  - Return is independent of stalls.
- Dependency: pass k+1 of nibble 0 is issued only after pass k of nibble NIBBLES-1 has been issued. Since NIBBLES ≥ 2, nibble 0's pass-k result is always written back before it is re-read.
- WAIT: capture the final result, go to DONE.
- DONE: out_valid=1. When out_ready=1, go to IDLE (out_valid low the next cycle).
- start in any state other than IDLE is ignored.
- Reset (rst_n=0, at any time including mid-run):
  - State returns to IDLE; both counters and ret_pending go to 0.
  - busy=0, out_valid=0, rnd_ready=0.
  - s_out* and the internal shares are cleared to 0.
  - A partly processed state is discarded.

## Timing
- start sampled at edge E: RUN starts in cycle E+1.
- No stalls: issues fall in cycles E+1 .. E+NIBBLES*PASSES, and out_valid rises NIBBLES*PASSES+2 cycles after E (50 with defaults).
- Each stalled cycle adds exactly one cycle of latency.
- s_out* are stable while out_valid=1.
- In the issue cycle, lay_* are valid combinationally from the registered state.
- Back-to-back operation: start may be accepted in the cycle right after the out_ready handshake, since IDLE lasts at least one cycle.

## Configuration
- SBOX_SEQ_ZEROIZE_EN defined:
  - On the out_ready handshake, the internal share registers are cleared to 0.
  - lay_in1..3 and lay_r/rc0/rc1 are forced to 0 in every cycle without an issue.
  - s_out* are cleared on the same edge that leaves DONE.
- SBOX_SEQ_ZEROIZE_EN undefined:
  - Share registers and s_out* keep their last values.
  - lay_* show nibble nib_cnt and rnd_in in non-issue cycles. The layer output in those cycles is ignored.

## Test plan
- Unstalled run, rnd_valid=1 constant, layer model = reference quadratic stages. Unmasked XOR of s_out equals SKINNY S-box applied to the unmasked input, e.g. input 0x0123456789ABCDEF. out_valid rises exactly 50 cycles after start; rnd_ready high for exactly 48 cycles.
- rnd_valid toggling 1,0,1,0: the result is unchanged, latency is 98 cycles, and every consumed rnd_in value appears on lay_r exactly once.
- Hold out_ready=0 for 10 cycles in DONE: out_valid and s_out are stable. A start pulse during that time is ignored, and busy stays 1.
- Assert rst_n=0 in cycle 20 of RUN: busy, out_valid, rnd_ready and s_out all go to 0 asynchronously. A start afterwards yields a correct result from fresh inputs.
- Start asserted in the cycle right after a handshake: the second result is correct, the first result has no residue in it, and lay_sel sequences 0 (×16), 1 (×16), 2 (×16).
- With SBOX_SEQ_ZEROIZE_EN: lay_in* and lay_r are 0 in IDLE, WAIT and stall cycles. s_out reads 0 after the handshake.
